// File: rtl/q8_8_sat_accum.sv
// Saturating Q8.8 frame accumulator behind the add/sub unit. It takes ACC_LEN clamped samples,
// then holds the frame total with a sticky saturation flag until the consumer takes it.
module q8_8_sat_accum #(
    parameter int BUS_WIDTH = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_LEN   = 8,
    localparam int CNT_W    = $clog2(ACC_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH:0]   in_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_sum,
    output logic                 out_sat,
    output logic [CNT_W-1:0]     out_count
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 sat_q, sat_d;

    logic                 accept;
    logic                 inClamp, sumClamp;
    logic [BUS_WIDTH-1:0] inSat, sumSat;
    logic [BUS_WIDTH:0]   sumWide;
    logic [CNT_W-1:0]     countInc;

    // A one-bit-wider value fits in BUS_WIDTH bits only when its top two bits agree.
    function automatic logic overflows(input logic [BUS_WIDTH:0] v);
        return v[BUS_WIDTH] ^ v[BUS_WIDTH-1];
    endfunction

    function automatic logic [BUS_WIDTH-1:0] clampWord(input logic [BUS_WIDTH:0] v);
        if (overflows(v)) begin
            return {v[BUS_WIDTH], {(BUS_WIDTH-1){~v[BUS_WIDTH]}}};
        end
        return v[BUS_WIDTH-1:0];
    endfunction

    always_comb begin
        inClamp  = overflows(in_result);
        inSat    = clampWord(in_result);
        sumWide  = {acc_q[BUS_WIDTH-1], acc_q} + {inSat[BUS_WIDTH-1], inSat};
        sumClamp = overflows(sumWide);
        sumSat   = clampWord(sumWide);
        countInc = count_q + CNT_W'(1);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // Clear outranks both the transfer and the acceptance.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear || (state_q == HOLD && out_ready)) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (accept) begin
            acc_d   = sumSat;
            count_d = countInc;
            sat_d   = sat_q | inClamp | sumClamp;
            if (countInc == CNT_W'(ACC_LEN)) begin
                state_d = HOLD;
            end
        end
    end

    always_comb begin
        in_ready  = rst_n && !clear && (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        out_sum   = acc_q;
        out_sat   = sat_q;
        out_count = count_q;
    end

endmodule

// File: doc/q8_8_sat_accum.md
# q8_8_sat_accum

Sequential stage directly downstream of the Q8.8 add/sub unit. Takes its 17-bit result through a valid/ready handshake and saturates it to signed Q8.8. Accumulates ACC_LEN such samples into a saturating 16-bit Q8.8 running sum, then holds the frame total for a downstream consumer with a sticky saturation flag. Gives the arithmetic unit a registered, back-pressurable output path.

## Interface

- BUS_WIDTH, 16, Q8.8 word width; input is BUS_WIDTH+1 bits.
- FRAC_BITS, 8, fractional bits; only used for documentation and test scaling, with no arithmetic effect.
- ACC_LEN, 8, samples per frame, ≥1.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- clear  input  1  synchronous frame abort/restart, active-high.
- in_valid  input  1  in_result is valid.
- in_ready  output  1  stage accepts a sample this cycle.
- in_result  input  BUS_WIDTH+1  signed two's-complement Q9.8 sample (bit 16 is sign).
- out_valid  output  1  frame total available.
- out_ready  input  1  consumer takes the total.
- out_sum  output  BUS_WIDTH  accumulator register, signed Q8.8.
- out_sat  output  1  sticky: some saturation occurred in the current frame.
- out_count  output  $clog2(ACC_LEN+1)  samples accepted in the current frame.

## Operation

- States: ACCUM and HOLD. Reset state is ACCUM.
- in_ready = rst_n && !clear && (state==ACCUM). It is combinational; no other input affects it.
- A sample is accepted on a rising edge with in_valid && in_ready.
- Input saturation:
  - s = in_result, signed 17-bit.
  - If s > 32767, then s16 = 0x7FFF. If s < −32768, then s16 = 0x8000. Otherwise s16 = s[15:0].
  - Clamping sets out_sat.
- Accumulation: the 17-bit signed sum acc + s16 is clamped the same way into acc. Clamping sets out_sat.
- On acceptance, out_count increments.
- If the acceptance makes out_count reach ACC_LEN, the state becomes HOLD.
- HOLD:
  - out_valid = 1 and in_ready = 0.
  - out_sum, out_sat and out_count are frozen.
  - in_valid is ignored.
- Transfer (out_valid && out_ready): on that edge acc=0, out_count=0, out_sat=0, state=ACCUM.
- clear=1 (when rst_n=1), from either state:
  - Next edge: acc=0, out_count=0, out_sat=0, state=ACCUM, out_valid=0.
  - A simultaneous in_valid sample is not accepted, because in_ready is 0.
  - A simultaneous out_ready does not count as a transfer.
- Priority: rst_n low > clear > transfer/acceptance.
- ACC_LEN=1: every accepted sample goes straight to HOLD.
- Saturation is not wrap-around. Once acc is clamped at 0x7FFF, later positive samples keep it there. Negative samples subtract from 0x7FFF normally.

## Timing

- Reset values, applied on the first edge with rst_n=0 and held while it stays low:
  - out_valid=0, out_sum=0x0000, out_sat=0, out_count=0, state=ACCUM.
  - in_ready=0 while rst_n=0.
- Acceptance to out_sum update: 1 cycle, registered.
- Last sample accepted at edge N: out_valid=1 from edge N onward, so it is visible in cycle N+1. out_sum holds the final total.
- Minimum frame period: ACC_LEN+1 cycles, i.e. ACC_LEN acceptances plus at least one HOLD cycle.
- Full throughput inside a frame: one sample per cycle with in_valid held high.
- HOLD with out_ready=0: all outputs stable indefinitely.
- Transfer at edge M: in_ready=1 in cycle M+1, with out_sum=0x0000 and out_count=0.
- Reset mid-frame or in HOLD: the frame is discarded with no output transfer.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_sum=0x0000, out_sat=0, out_count=0. After release, in_ready=1.
- Nominal frame (ACC_LEN=4): in_result=0x00100 (1.0) ×4 back-to-back -> out_count steps 1..4. out_valid=1 in the cycle after the 4th acceptance, with out_sum=0x0400 and out_sat=0. in_ready=0 in HOLD.
- Input clamp (ACC_LEN=1):
  - 0x0C000 (+49152) -> out_sum=0x7FFF, out_sat=1.
  - Next frame, 0x10000 (−65536) -> out_sum=0x8000, out_sat=1.
- Accumulator clamp (ACC_LEN=4): 0x06000, 0x06000, 0x1FF00, 0x00100 -> sum after sample 2 = 0x7FFF, after 3 = 0x7EFF, final = 0x7FFF, out_sat=1.
- Backpressure: in HOLD, out_ready=0 for 5 cycles with in_valid=1 -> out_valid=1, with out_sum and out_count unchanged and no acceptance. Raising out_ready gives in_ready=1, out_sum=0x0000, out_count=0 the next cycle.
- Clear:
  - After 2 accepted samples, assert clear together with in_valid -> sample not accepted, next cycle out_count=0 and out_sum=0x0000.
  - In HOLD, assert clear together with out_ready -> out_valid=0 next cycle, no transfer counted, state ACCUM.
